// File: rtl/ntt_result_collector_if.sv
// Result-stream and readback bundle between the NTT core side and ntt_result_collector.
interface ntt_result_collector_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              done;
  logic [DATA_W-1:0] dout0;
  logic [11:0]       ring_size;
  logic [DATA_W-1:0] q;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              cap_done;
  logic [ADDR_W:0]   word_cnt;

  modport master (
    output done, dout0, ring_size, q, rd_addr,
    input  rd_data, busy, cap_done, word_cnt
  );

  modport slave (
    input  done, dout0, ring_size, q, rd_addr,
    output rd_data, busy, cap_done, word_cnt
  );
endinterface

// File: rtl/ntt_result_collector.sv
// Captures the NTT core's burst-framed result stream and de-interleaves it into natural order.
// Optional conditional subtract of q on write: define NTT_COLLECT_REDUCE_EN.
//
// state | meaning
// IDLE  | waiting for a rising edge of done
// BURST | sampling one word per cycle into the buffer
// GAP   | one idle beat between bursts, dout0 ignored
// FIN   | capture complete, buffer holds the result
module ntt_result_collector #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int PE_DEPTH = 2
) (
  input logic              clk,
  input logic              reset,
  ntt_result_collector_if.slave bus
);
  localparam int BW   = PE_DEPTH + 1;
  localparam int BEAT = 1 << BW;

  typedef enum logic [1:0] {IDLE, BURST, GAP, FIN} state_t;

  state_t            state;
  logic              done_d;
  logic              busy;
  logic              cap_done;
  logic [ADDR_W:0]   wc;
  logic [BW-1:0]     beat;
  logic [11:0]       burst_cnt;
  logic [11:0]       nb_lat;
  logic [ADDR_W-1:0] half_lat;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              trig;
  logic [11:0]       nb_new;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  assign trig   = bus.done & ~done_d;
  assign nb_new = bus.ring_size >> BW;

  // A restart trigger takes priority over the word arriving in the same cycle.
  assign we    = (state == BURST) && !reset && !trig;
  assign waddr = wc[0] ? (wc[ADDR_W:1] + half_lat) : wc[ADDR_W:1];

`ifdef NTT_COLLECT_REDUCE_EN
  assign wdata = (bus.dout0 >= bus.q) ? (bus.dout0 - bus.q) : bus.dout0;
`else
  assign wdata = bus.dout0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      done_d    <= 1'b0;
      busy      <= 1'b0;
      cap_done  <= 1'b0;
      wc        <= '0;
      beat      <= '0;
      burst_cnt <= '0;
      nb_lat    <= '0;
      half_lat  <= '0;
    end else begin
      done_d <= bus.done;
      if (trig) begin
        nb_lat    <= nb_new;
        half_lat  <= bus.ring_size[ADDR_W:1];
        wc        <= '0;
        beat      <= '0;
        burst_cnt <= '0;
        if (nb_new == 12'd0) begin
          state    <= FIN;
          busy     <= 1'b0;
          cap_done <= 1'b1;
        end else begin
          state    <= BURST;
          busy     <= 1'b1;
          cap_done <= 1'b0;
        end
      end else begin
        case (state)
          BURST: begin
            wc   <= wc + 1'b1;
            beat <= beat + 1'b1;
            if (beat == BW'(BEAT - 1)) state <= GAP;
          end
          GAP: begin
            burst_cnt <= burst_cnt + 12'd1;
            if (burst_cnt + 12'd1 == nb_lat) begin
              state    <= FIN;
              busy     <= 1'b0;
              cap_done <= 1'b1;
            end else begin
              state <= BURST;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Non-blocking read of the array gives old data on a same-address write.
  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[bus.rd_addr];
  end

  assign bus.rd_data  = rd_data;
  assign bus.busy     = busy;
  assign bus.cap_done = cap_done;
  assign bus.word_cnt = wc;
endmodule

// File: tb/tb_ntt_result_collector.sv
// Directed self-checking bench for ntt_result_collector (default parameters).
module tb_ntt_result_collector;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   errors = 0;
  int   cyc;

  ntt_result_collector_if #(.DATA_W(32), .ADDR_W(10)) bus ();

  ntt_result_collector #(.DATA_W(32), .ADDR_W(10), .PE_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_val(input int mode, input int m);
    if (mode == 1 && m == 0) return 32'd3330;
    if (mode == 1 && m == 1) return 32'd3328;
    if (mode == 1 && m == 2) return 32'd6657;
    if (mode == 2) return 32'(m + 1000);
    return 32'(m + 1);
  endfunction

  // Triggers a run and streams 8 words + 1 gap per burst; returns cycles from trigger to cap_done.
  task automatic run(input int rs, input int mode, input int abort_at, output int cyc_o);
    int wc_exp;
    int p;
    @(negedge clk);
    bus.done = 1'b0;
    @(negedge clk);
    bus.ring_size = 12'(rs);
    bus.done = 1'b1;
    @(posedge clk);
    wc_exp = 0;
    cyc_o = -1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      check("word_cnt_track", 64'(bus.word_cnt), 64'(wc_exp));
      if (c == 0 && rs >= 8) begin
        check("start_busy", 64'(bus.busy), 64'd1);
        check("start_cap_done", 64'(bus.cap_done), 64'd0);
      end
      if (bus.cap_done === 1'b1 || c == abort_at) begin
        cyc_o = c;
        break;
      end
      p = c % 9;
      if (p < 8) begin
        bus.dout0 = word_val(mode, (c / 9) * 8 + p);
        wc_exp++;
      end else begin
        bus.dout0 = 32'hDEADBEEF;
      end
      @(posedge clk);
    end
  endtask

  task automatic rd(input int a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    bus.rd_addr = 10'(a);
    @(negedge clk);
    check(tag, 64'(bus.rd_data), 64'(exp));
  endtask

  initial begin
    bus.done = 1'b0;
    bus.dout0 = '0;
    bus.ring_size = 12'd256;
    bus.q = 32'd3329;
    bus.rd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_cap_done", 64'(bus.cap_done), 64'd0);
    check("rst_word_cnt", 64'(bus.word_cnt), 64'd0);
    check("rst_rd_data", 64'(bus.rd_data), 64'd0);
    reset = 1'b0;

    // conditional-subtract run
    run(256, 1, -1, cyc);
    check("red_cycles", 64'(cyc), 64'd288);
    check("red_word_cnt", 64'(bus.word_cnt), 64'd256);
    check("red_busy", 64'(bus.busy), 64'd0);
`ifdef NTT_COLLECT_REDUCE_EN
    rd(0, 32'd1, "red_mem0");
    rd(1, 32'd3328, "red_mem1");
`else
    rd(0, 32'd3330, "raw_mem0");
    rd(1, 32'd6657, "raw_mem1");
`endif
    rd(128, 32'd3328, "red_mem128");

    // done held high: no retrigger
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      check("hold_busy", 64'(bus.busy), 64'd0);
      check("hold_cap_done", 64'(bus.cap_done), 64'd1);
    end
    check("hold_word_cnt", 64'(bus.word_cnt), 64'd256);

    // new rising edge restarts; full readback checks order and absence of gap words
    run(256, 0, -1, cyc);
    check("r256_cycles", 64'(cyc), 64'd288);
    check("r256_word_cnt", 64'(bus.word_cnt), 64'd256);
    for (int a = 0; a < 256; a++) begin
      if (a < 128) rd(a, 32'(2 * a + 1), "r256_mem_even");
      else         rd(a, 32'(2 * (a - 128) + 2), "r256_mem_odd");
    end

    // reset after 40 words
    run(256, 2, 45, cyc);
    check("abort_cycles", 64'(cyc), 64'd45);
    reset = 1'b1;
    bus.done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_cap_done", 64'(bus.cap_done), 64'd0);
    check("abort_word_cnt", 64'(bus.word_cnt), 64'd0);
    for (int a = 0; a < 20; a++) begin
      rd(a, 32'(2 * a + 1000), "abort_mem_even");
      rd(128 + a, 32'(2 * a + 1001), "abort_mem_odd");
    end
    rd(20, 32'd41, "abort_mem20_untouched");
    rd(148, 32'd42, "abort_mem148_untouched");

    run(256, 0, -1, cyc);
    check("post_abort_cycles", 64'(cyc), 64'd288);
    rd(0, 32'd1, "post_abort_mem0");
    rd(255, 32'd256, "post_abort_mem255");

    // largest ring
    run(1024, 0, -1, cyc);
    check("r1024_cycles", 64'(cyc), 64'd1152);
    check("r1024_word_cnt", 64'(bus.word_cnt), 64'd1024);
    rd(512, 32'd2, "r1024_mem512");
    rd(1, 32'd3, "r1024_mem1");
    rd(1023, 32'd1024, "r1024_mem1023");

    // ring smaller than one burst: immediate finish, no writes
    run(4, 0, -1, cyc);
    check("r4_cycles", 64'(cyc), 64'd0);
    check("r4_word_cnt", 64'(bus.word_cnt), 64'd0);
    check("r4_busy", 64'(bus.busy), 64'd0);
    rd(0, 32'd1, "r4_mem0");
    rd(2, 32'd5, "r4_mem2");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/ntt_result_collector.md
Name: ntt_result_collector

Overview:
- Sink-side unloader for the NTT core's result stream. It is the reader for the core's `dout0`/`done` writer.
- After `done` rises, it captures the burst-framed output words and de-interleaves even/odd beats into natural coefficient order.
- Coefficients are stored in an internal buffer, with optional final reduction mod q.
- Sits between NTT1024 and the host/readback logic, replacing bench-side collection.

Parameters:
- DATA_W, 32, width of `dout0` and of stored coefficients.
- ADDR_W, 10, buffer address width; holds up to 1024 coefficients.
- PE_DEPTH, 2, log2 of the core's PE count. Burst length BEAT = 2^(PE_DEPTH+1) words (8 at default).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- done  in  1  core completion flag; only its rising edge is used.
- dout0  in  DATA_W  core output word.
- ring_size  in  12  number of coefficients; power of two, BEAT..1024.
- q  in  DATA_W  modulus used by final reduction.
- rd_addr  in  ADDR_W  buffer read address, natural order.
- rd_data  out  DATA_W  buffer read data; 1-cycle latency.
- busy  out  1  capture in progress.
- cap_done  out  1  capture complete, result valid.
- word_cnt  out  ADDR_W+1  number of words captured in the current run.

Behaviour:
- Reset values: `busy`=0, `cap_done`=0, `word_cnt`=0, `rd_data`=0, state=IDLE. Buffer contents are not cleared.
- Reset asserted mid-capture aborts the run immediately. Values already written stay in the buffer.
- Trigger: `done` & ~done_d, where done_d is registered. `done` held high does not retrigger.
- On trigger at edge k:
  - latch `ring_size`; NB = ring_size >> (PE_DEPTH+1); HALF = ring_size >> 1;
  - clear `word_cnt`, beat counter and burst counter; clear `cap_done`; set `busy`;
  - go to BURST, or to FIN directly if NB == 0 (no writes).
- States:
  - IDLE: wait for trigger.
  - BURST: at each edge, sample `dout0` as word m = `word_cnt`.
    - Write address = m>>1 when m even, (m>>1)+HALF when m odd.
    - Increment `word_cnt` and the beat counter.
    - After BEAT words, go to GAP.
  - GAP: one cycle, `dout0` ignored; increment burst counter. Go to FIN if burst count == NB, else back to BURST.
  - FIN: `busy`=0, `cap_done`=1; hold until the next trigger or reset.
- Timing: word 0 is sampled at edge k+1. The run occupies NB*(BEAT+1) cycles. `cap_done` is first high after edge k+NB*(BEAT+1).
- A trigger in BURST or GAP restarts capture from word 0; the partial run is discarded.
- Word values are not inspected; zero-valued words are captured normally.
- Read port:
  - synchronous: `rd_data` <= mem[rd_addr] each cycle;
  - usable in any state;
  - a read and a write to the same address in the same cycle returns the old data;
  - addresses ≥ latched ring_size return stale contents.
- `ring_size` changes after the trigger have no effect until the next trigger.

Optional Feature:
- Macro: NTT_COLLECT_REDUCE_EN.
- Defined: each word is written as (w >= q) ? w - q : w. This is a single conditional subtract; no full modular reduction.
- Undefined: the raw `dout0` is stored. The comparator and subtractor are not built, and `q` is unused.

Test Plan:
- ring_size=256, PE_DEPTH=2, stream word m = m+1, one gap cycle after every 8 words, 32 bursts. Required:
  - mem[0]=1, mem[128]=2, mem[1]=3, mem[255]=256;
  - `cap_done` high exactly 288 cycles after edge k;
  - `word_cnt`=256.
- With NTT_COLLECT_REDUCE_EN, q=3329, word 0 = 3330, word 1 = 3328, word 2 = 6657. Required: mem[0]=1, mem[128]=3328, mem[1]=3328. Without the macro: mem[0]=3330.
- Gap-cycle values set to 0xDEADBEEF. Required: none of them written to the buffer; `word_cnt` advances only in BURST.
- `done` held high for 500 cycles after a run. Required: a single capture and no retrigger. A new rising edge after FIN clears `cap_done` and restarts the run with `word_cnt`=0.
- Reset pulsed after 40 words of a 256-word run. Required:
  - next cycle `busy`=0, `cap_done`=0, `word_cnt`=0;
  - mem[0..19] and mem[128..147] retain their written values;
  - a subsequent trigger completes normally.
- ring_size=1024, then ring_size=4 (< BEAT). Required:
  - 1024: 128 bursts; odd word 1 lands at mem[512];
  - 4: NB=0, immediate FIN, no writes, `word_cnt`=0.
